// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement scheduler: state encoding,
// data widths and a counter-width helper.
package dht11_pkg;

  localparam int unsigned ESTADO_W   = 4;
  localparam int unsigned DADO_W     = 16;
  localparam int unsigned NFALHAS_W  = 8;
  localparam int unsigned TENTATIVA_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL  = 4'd0,
    OCIOSO   = 4'd1,
    DISPARA  = 4'd2,
    AGUARDA  = 4'd3,
    REGISTRA = 4'd4,
    FALHOU   = 4'd5,
    PAUSA    = 4'd6
  } estado_t;

  // Bits needed to count 0..modulo-1 (at least one bit).
  function automatic int unsigned largura_para(input int unsigned modulo);
    return (modulo > 1) ? $clog2(modulo) : 1;
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter: counts 0..MODULO-1 while enabled and holds there.
// Ports: clk, rst_n (async, active-low), limpa (sync clear, wins over
// habilita), habilita (count enable), fim_c (combinational: value at
// MODULO-1).
module contador_sat #(
  parameter int unsigned LARGURA = 8,
  parameter int unsigned MODULO  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa,
  input  logic habilita,
  output logic fim_c
);

  logic [LARGURA-1:0] valor;

  assign fim_c = (valor == LARGURA'(MODULO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                valor <= '0;
    else if (limpa)            valor <= '0;
    else if (habilita && !fim_c) valor <= valor + LARGURA'(1);
  end

endmodule

// File: rtl/dht11_agendador.sv
// DHT11 measurement scheduler: triggers the bus driver periodically or on
// request, supervises each transaction with a timeout and bounded retries,
// and latches the last good humidity/temperature pair.
// Ports: clock, reset_n (async, active-low); habilita (periodic enable),
// medir (one-shot request); dht_pronto/dht_error/dht_umidade/
// dht_temperatura from the driver; dht_start to the driver; umidade,
// temperatura, valido, nova_leitura, falha, n_falhas, db_estado status.
module dht11_agendador
  import dht11_pkg::*;
#(
  parameter int unsigned PERIODO         = 100_000_000,
  parameter int unsigned TIMEOUT         = 1_500_000,
  parameter int unsigned MAX_TENTATIVAS  = 3,
  parameter int unsigned INTERVALO_RETRY = 5_000_000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  habilita,
  input  logic                  medir,
  input  logic                  dht_pronto,
  input  logic                  dht_error,
  input  logic [DADO_W-1:0]     dht_umidade,
  input  logic [DADO_W-1:0]     dht_temperatura,
  output logic                  dht_start,
  output logic [DADO_W-1:0]     umidade,
  output logic [DADO_W-1:0]     temperatura,
  output logic                  valido,
  output logic                  nova_leitura,
  output logic                  falha,
  output logic [NFALHAS_W-1:0]  n_falhas,
  output logic [ESTADO_W-1:0]   db_estado
);

  localparam int unsigned CP_W = largura_para(PERIODO);
  localparam int unsigned TO_W = largura_para(TIMEOUT);
  localparam int unsigned PA_W = largura_para(INTERVALO_RETRY);

  estado_t                estado, prox;
  logic [TENTATIVA_W-1:0] tent, tent_d;
  logic [DADO_W-1:0]      umidade_d, temperatura_d;
  logic [NFALHAS_W-1:0]   n_falhas_d;
  logic                   valido_d, nova_d, falha_d, start_d;
  logic                   cp_limpa_c, cp_fim_c, to_fim_c, pa_fim_c;

  // Period counter runs in every state; only a new measurement restarts it.
  contador_sat #(.LARGURA(CP_W), .MODULO(PERIODO)) u_periodo (
    .clk(clock), .rst_n(reset_n), .limpa(cp_limpa_c), .habilita(1'b1),
    .fim_c(cp_fim_c)
  );

  contador_sat #(.LARGURA(TO_W), .MODULO(TIMEOUT)) u_timeout (
    .clk(clock), .rst_n(reset_n), .limpa(estado == DISPARA),
    .habilita(estado == AGUARDA), .fim_c(to_fim_c)
  );

  contador_sat #(.LARGURA(PA_W), .MODULO(INTERVALO_RETRY)) u_pausa (
    .clk(clock), .rst_n(reset_n), .limpa(estado == FALHOU),
    .habilita(estado == PAUSA), .fim_c(pa_fim_c)
  );

  assign cp_limpa_c = (estado == OCIOSO) && (prox == DISPARA);
  assign db_estado  = estado;

  // Next state and next values of every registered output; the data and
  // status are loaded on entry to REGISTRA so they are visible there.
  always_comb begin
    prox          = estado;
    tent_d        = tent;
    umidade_d     = umidade;
    temperatura_d = temperatura;
    valido_d      = valido;
    nova_d        = 1'b0;
    falha_d       = falha;
    n_falhas_d    = n_falhas;
    case (estado)
      INICIAL: prox = OCIOSO;
      OCIOSO: begin
        if (medir || (habilita && cp_fim_c)) prox = DISPARA;
      end
      DISPARA: begin
        tent_d = tent + TENTATIVA_W'(1);
        prox   = AGUARDA;
      end
      AGUARDA: begin
        if (dht_error) begin
          prox = FALHOU;
        end else if (dht_pronto) begin
          prox          = REGISTRA;
          umidade_d     = dht_umidade;
          temperatura_d = dht_temperatura;
          nova_d        = 1'b1;
          valido_d      = 1'b1;
          falha_d       = 1'b0;
          tent_d        = '0;
        end else if (to_fim_c) begin
          prox = FALHOU;
        end
      end
      REGISTRA: prox = OCIOSO;
      FALHOU: begin
        if (tent < TENTATIVA_W'(MAX_TENTATIVAS)) begin
          prox = PAUSA;
        end else begin
          falha_d    = 1'b1;
          n_falhas_d = (n_falhas == '1) ? n_falhas : n_falhas + NFALHAS_W'(1);
          tent_d     = '0;
          prox       = OCIOSO;
        end
      end
      PAUSA: begin
        if (pa_fim_c) prox = DISPARA;
      end
      default: prox = INICIAL;
    endcase
    start_d = (prox == DISPARA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= INICIAL;
      tent         <= '0;
      umidade      <= '0;
      temperatura  <= '0;
      valido       <= 1'b0;
      nova_leitura <= 1'b0;
      falha        <= 1'b0;
      n_falhas     <= '0;
      dht_start    <= 1'b0;
    end else begin
      estado       <= prox;
      tent         <= tent_d;
      umidade      <= umidade_d;
      temperatura  <= temperatura_d;
      valido       <= valido_d;
      nova_leitura <= nova_d;
      falha        <= falha_d;
      n_falhas     <= n_falhas_d;
      dht_start    <= start_d;
    end
  end

endmodule

// File: tb/tb_dht11_agendador.sv
// Directed bench for dht11_agendador with small timing parameters. The
// sequencer plays the role of the DHT11 driver; sampling and driving happen
// 1 time unit after each rising edge, and cyc counts rising edges.
module tb_dht11_agendador;

  localparam int unsigned PERIODO = 100;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned MAXT    = 3;
  localparam int unsigned RETRY   = 20;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        habilita, medir, dht_pronto, dht_error;
  logic [15:0] dht_umidade, dht_temperatura;
  logic        dht_start, valido, nova_leitura, falha;
  logic [15:0] umidade, temperatura;
  logic [7:0]  n_falhas;
  logic [3:0]  db_estado;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  dht11_agendador #(
    .PERIODO(PERIODO), .TIMEOUT(TIMEOUT),
    .MAX_TENTATIVAS(MAXT), .INTERVALO_RETRY(RETRY)
  ) dut (
    .clock(clock), .reset_n(reset_n), .habilita(habilita), .medir(medir),
    .dht_pronto(dht_pronto), .dht_error(dht_error),
    .dht_umidade(dht_umidade), .dht_temperatura(dht_temperatura),
    .dht_start(dht_start), .umidade(umidade), .temperatura(temperatura),
    .valido(valido), .nova_leitura(nova_leitura), .falha(falha),
    .n_falhas(n_falhas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Advance until dht_start is seen; returns the cycle it was seen.
  task automatic wait_start(output int at);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (dht_start) begin
        at = cyc;
        return;
      end
    end
    chk("start_wait", 32'd0, 32'd1);
    at = cyc;
  endtask

  // One-cycle medir in OCIOSO; start must follow on the next edge.
  task automatic trigger();
    medir = 1'b1;
    tick();
    medir = 1'b0;
    chk("trig_start", 32'(dht_start), 32'd1);
  endtask

  // Completion pulse dly cycles after the start; bus is then scrambled.
  task automatic respond_ok(input int dly, input logic [15:0] u, input logic [15:0] t);
    for (int i = 0; i < dly; i++) tick();
    dht_pronto = 1'b1; dht_umidade = u; dht_temperatura = t;
    tick();
    dht_pronto = 1'b0; dht_umidade = 16'hffff; dht_temperatura = 16'heeee;
    chk("nova_pulse", 32'(nova_leitura), 32'd1);
    chk("st_registra", 32'(db_estado), 32'd4);
    tick();
    chk("nova_once", 32'(nova_leitura), 32'd0);
    chk("st_ocioso", 32'(db_estado), 32'd1);
  endtask

  // Error pulse dly cycles after the start (optionally with pronto too).
  task automatic respond_err(input int dly, input logic both, output int x);
    for (int i = 0; i < dly; i++) tick();
    dht_error = 1'b1;
    if (both) begin
      dht_pronto = 1'b1; dht_umidade = 16'hdead; dht_temperatura = 16'hbeef;
    end
    x = cyc;
    tick();
    dht_error = 1'b0; dht_pronto = 1'b0;
    chk("st_falhou", 32'(db_estado), 32'd5);
  endtask

  // A full measurement cycle where every attempt errors out immediately.
  task automatic fail_cycle();
    int s;
    trigger();
    for (int a = 0; a < int'(MAXT); a++) begin
      if (a > 0) wait_start(s);
      tick();
      dht_error = 1'b1;
      tick();
      dht_error = 1'b0;
    end
    tick();
  endtask

  initial begin
    int t0, s1, s2, x, d1, d2, n;
    reset_n = 1'b0; habilita = 1'b1; medir = 1'b0;
    dht_pronto = 1'b0; dht_error = 1'b0;
    dht_umidade = 16'h0; dht_temperatura = 16'h0;
    tick(); tick();

    // Reset state
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_start", 32'(dht_start), 32'd0);
    chk("rst_umid", 32'(umidade), 32'd0);
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_falha", 32'(falha), 32'd0);
    chk("rst_nfalhas", 32'(n_falhas), 32'd0);

    // 1: periodic mode. Start high in the 101st period after release,
    // i.e. 100 rising edges later.
    reset_n = 1'b1;
    t0 = cyc;
    wait_start(s1);
    chk("t1_first_start", 32'(s1 - t0), 32'd100);
    tick();
    chk("t1_start_pulse", 32'(dht_start), 32'd0);
    respond_ok(9, 16'h1234, 16'h5abc);
    chk("t1_umid", 32'(umidade), 32'h1234);
    chk("t1_temp", 32'(temperatura), 32'h5abc);
    chk("t1_valido", 32'(valido), 32'd1);
    wait_start(s2);
    chk("t1_period", 32'(s2 - s1), 32'd100);
    respond_ok(10, 16'h1234, 16'h5abc);

    // 2: one-shot request only
    habilita = 1'b0;
    trigger();
    respond_ok(10, 16'h0a0b, 16'h0c0d);
    chk("t2_umid", 32'(umidade), 32'h0a0b);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      n += int'(dht_start);
    end
    chk("t2_no_more_starts", 32'(n), 32'd0);

    // 3: two driver errors, then success
    trigger();
    respond_err(3, 1'b0, x);
    wait_start(s1);
    chk("t3_retry1", 32'(s1 - x), 32'd22);
    respond_err(3, 1'b0, x);
    wait_start(s1);
    chk("t3_retry2", 32'(s1 - x), 32'd22);
    respond_ok(5, 16'h3800, 16'h1900);
    chk("t3_umid", 32'(umidade), 32'h3800);
    chk("t3_temp", 32'(temperatura), 32'h1900);
    chk("t3_falha", 32'(falha), 32'd0);
    chk("t3_nfalhas", 32'(n_falhas), 32'd0);

    // 4: driver silent; each attempt times out
    trigger();
    d1 = cyc;
    wait_start(d2);
    chk("t4_retry1", 32'(d2 - d1), 32'd72);
    wait_start(d1);
    chk("t4_retry2", 32'(d1 - d2), 32'd72);
    for (int i = 0; i < 50; i++) tick();
    chk("t4_still_wait", 32'(db_estado), 32'd3);
    tick();
    chk("t4_timed_out", 32'(db_estado), 32'd5);
    tick();
    chk("t4_ocioso", 32'(db_estado), 32'd1);
    chk("t4_falha", 32'(falha), 32'd1);
    chk("t4_nfalhas", 32'(n_falhas), 32'd1);
    chk("t4_umid_kept", 32'(umidade), 32'h3800);
    chk("t4_temp_kept", 32'(temperatura), 32'h1900);
    chk("t4_valido_kept", 32'(valido), 32'd1);
    trigger();
    respond_ok(10, 16'h4455, 16'h6677);
    chk("t4_falha_clr", 32'(falha), 32'd0);
    chk("t4_nfalhas_kept", 32'(n_falhas), 32'd1);

    // 5: simultaneous pronto+error is an error; stray pronto ignored
    trigger();
    respond_err(3, 1'b1, x);
    chk("t5_umid_kept", 32'(umidade), 32'h4455);
    chk("t5_nova_none", 32'(nova_leitura), 32'd0);
    wait_start(s1);
    chk("t5_retry", 32'(s1 - x), 32'd22);
    respond_ok(4, 16'h1111, 16'h2222);
    chk("t5_umid", 32'(umidade), 32'h1111);
    dht_pronto = 1'b1; dht_umidade = 16'h9999; dht_temperatura = 16'h8888;
    tick();
    dht_pronto = 1'b0;
    chk("t5_stray_estado", 32'(db_estado), 32'd1);
    tick();
    chk("t5_stray_nova", 32'(nova_leitura), 32'd0);
    chk("t5_stray_umid", 32'(umidade), 32'h1111);
    chk("t5_stray_temp", 32'(temperatura), 32'h2222);

    // 6: async reset mid-transaction, then failure-counter saturation
    trigger();
    tick(); tick(); tick();
    chk("t6_aguarda", 32'(db_estado), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_estado", 32'(db_estado), 32'd0);
    chk("t6_rst_umid", 32'(umidade), 32'd0);
    chk("t6_rst_valido", 32'(valido), 32'd0);
    chk("t6_rst_nfalhas", 32'(n_falhas), 32'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    for (int k = 0; k < 255; k++) fail_cycle();
    chk("t6_nfalhas_255", 32'(n_falhas), 32'd255);
    fail_cycle();
    chk("t6_nfalhas_sat", 32'(n_falhas), 32'd255);
    chk("t6_falha", 32'(falha), 32'd1);
    chk("t6_ocioso", 32'(db_estado), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
